// File: rtl/alu_tr_pkg.sv
// Shared definitions for the time-redundant ALU: opcodes, FSM encoding and
// the width of the compared {Result, Z, C, V, N} tuple.
package alu_tr_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EX1  = 3'd1,
        ST_EX2  = 3'd2,
        ST_EX3  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Result plus the four flags Z, C, V, N.
    function automatic int tuple_w(input int width);
        return width + 4;
    endfunction

endpackage

// File: rtl/alu_tr_core.sv
// Combinational ALU core shared by all executions; produces the full
// {Result, Z, C, V, N} tuple with the injection mask applied before Z/N.
module alu_tr_core
    import alu_tr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic [2:0]                op,
    input  logic [WIDTH-1:0]          fault_inj,
    output logic [tuple_w(WIDTH)-1:0] tuple
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_f;
    logic             c;
    logic             v;

    // Subtraction as A + ~B + 1, so the carry-out means "no borrow".
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = dif[WIDTH-1:0];
                c   = dif[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res = '0;
        endcase
        res_f = res ^ fault_inj;
    end

    assign tuple = {res_f, (res_f == '0), c, v, res_f[WIDTH-1]};

endmodule

// File: rtl/alu_tr_voter.sv
// Time-redundant ALU: each operation runs twice on one core, a third run
// votes on mismatch, and unresolved votes retry up to MAX_RETRY rounds.
module alu_tr_voter
    import alu_tr_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] fault_inj,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             OverFlow,
    output logic             Negative,
    output logic             fault_detected,
    output logic             uncorrectable,
    output logic [CNT_W-1:0] fault_count
);

    localparam int TW = tuple_w(WIDTH);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [TW-1:0]    t1_q, t1_d, t2_q, t2_d, out_q, out_d;
    logic [TW-1:0]    core_t;
    logic [RW-1:0]    retry_q, retry_d;
    logic             op_fault_q, op_fault_d;
    logic             fault_q, fault_d;
    logic             unc_q, unc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_done;

    alu_tr_core #(.WIDTH(WIDTH)) u_core (
        .a         (a_q),
        .b         (b_q),
        .op        (op_q),
        .fault_inj (fault_inj),
        .tuple     (core_t)
    );

    // Valid/ready: a transfer happens on a clock edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        out_d      = out_q;
        retry_d    = retry_q;
        op_fault_d = op_fault_q;
        fault_d    = fault_q;
        unc_d      = unc_q;
        cnt_d      = cnt_q;
        load_done  = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                a_d        = A;
                b_d        = B;
                op_d       = ALUControl;
                op_fault_d = 1'b0;
                retry_d    = '0;
                state_d    = ST_EX1;
            end
            ST_EX1: begin
                t1_d    = core_t;
                state_d = ST_EX2;
            end
            ST_EX2: begin
                t2_d = core_t;
                if (core_t == t1_q) begin
                    out_d     = core_t;
                    unc_d     = 1'b0;
                    load_done = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    op_fault_d = 1'b1;
                    state_d    = ST_EX3;
                end
            end
            ST_EX3: begin
                if (core_t == t1_q || core_t == t2_q) begin
                    out_d     = core_t;
                    unc_d     = 1'b0;
                    load_done = 1'b1;
                    state_d   = ST_DONE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_EX1;
                end else begin
                    out_d     = core_t;
                    unc_d     = 1'b1;
                    load_done = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: if (out_ready) begin
                retry_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // op_fault_q already holds any mismatch seen in earlier rounds.
        if (load_done) fault_d = op_fault_q;

        if (cnt_clr)
            cnt_d = '0;
        else if (load_done && op_fault_q && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            out_q      <= '0;
            retry_q    <= '0;
            op_fault_q <= 1'b0;
            fault_q    <= 1'b0;
            unc_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            out_q      <= out_d;
            retry_q    <= retry_d;
            op_fault_q <= op_fault_d;
            fault_q    <= fault_d;
            unc_q      <= unc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready       = (state_q == ST_IDLE);
    assign out_valid      = (state_q == ST_DONE);
    assign Result         = out_q[TW-1:4];
    assign Zero           = out_q[3];
    assign Carry          = out_q[2];
    assign OverFlow       = out_q[1];
    assign Negative       = out_q[0];
    assign fault_detected = fault_q;
    assign uncorrectable  = unc_q;
    assign fault_count    = cnt_q;

endmodule

// File: tb/tb_alu_tr_voter.sv
// Directed bench for alu_tr_voter: table of fault-free ops plus hand-written
// fault, backpressure, saturation and reset sequences.
module tb_alu_tr_voter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, cnt_clr;
    logic [31:0] A, B, fault_inj;
    logic [2:0]  ALUControl;

    logic        in_ready, out_valid, Zero, Carry, OverFlow, Negative;
    logic        fault_detected, uncorrectable;
    logic [31:0] Result;
    logic [7:0]  fault_count;

    logic        s_in_ready, s_out_valid, s_zero, s_carry, s_ovf, s_neg, s_fault, s_unc;
    logic [31:0] s_result;
    logic [1:0]  s_count;

    int tests = 0;
    int fails = 0;

    logic [31:0] inj_sched[40];
    logic        clr_sched[40];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic [3:0]  zcvn;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    alu_tr_voter #(.WIDTH(32), .MAX_RETRY(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .fault_inj(fault_inj),
        .cnt_clr(cnt_clr), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .Carry(Carry), .OverFlow(OverFlow),
        .Negative(Negative), .fault_detected(fault_detected),
        .uncorrectable(uncorrectable), .fault_count(fault_count)
    );

    // Narrow-counter copy driven by the same stimulus, used for saturation.
    alu_tr_voter #(.WIDTH(32), .MAX_RETRY(2), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .fault_inj(fault_inj),
        .cnt_clr(cnt_clr), .out_valid(s_out_valid), .out_ready(out_ready),
        .Result(s_result), .Zero(s_zero), .Carry(s_carry), .OverFlow(s_ovf),
        .Negative(s_neg), .fault_detected(s_fault),
        .uncorrectable(s_unc), .fault_count(s_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_sched();
        for (int k = 0; k < 40; k++) begin
            inj_sched[k] = '0;
            clr_sched[k] = 1'b0;
        end
    endtask

    // Latency counts clock edges from the accept edge (inclusive) to the
    // edge after which out_valid is seen high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, output int lat);
        @(negedge clk);
        A = a; B = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ALUControl = 3'($urandom_range(0, 7));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
            fault_inj = inj_sched[k];
            cnt_clr   = clr_sched[k];
            @(posedge clk);
            lat++;
        end
        fault_inj = '0;
        cnt_clr   = 1'b0;
        check("op_completes", 64'(out_valid), 64'd1);
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 4'b0011};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 4'b1100};
        vecs[2]  = '{32'h00000005, 32'h00000003, 3'b001, 32'h00000002, 4'b0100};
        vecs[3]  = '{32'h00000003, 32'h00000005, 3'b001, 32'hFFFFFFFE, 4'b0001};
        vecs[4]  = '{32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 4'b0110};
        vecs[5]  = '{32'h00000007, 32'h00000007, 3'b001, 32'h00000000, 4'b1100};
        vecs[6]  = '{32'h0000F0F0, 32'h0000FF00, 3'b010, 32'h0000F000, 4'b0000};
        vecs[7]  = '{32'h12340000, 32'h00005678, 3'b011, 32'h12345678, 4'b0000};
        vecs[8]  = '{32'hAAAA5555, 32'hAAAA5555, 3'b100, 32'h00000000, 4'b1000};
        vecs[9]  = '{32'h80000000, 32'h00000000, 3'b100, 32'h80000000, 4'b0001};
        vecs[10] = '{32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000001, 4'b0000};
        vecs[11] = '{32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000000, 4'b1000};
        vecs[12] = '{32'h00000005, 32'h00000003, 3'b110, 32'h00000000, 4'b1000};
        vecs[13] = '{32'h00000005, 32'h00000003, 3'b111, 32'h00000000, 4'b1000};

        clear_sched();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        A = '0; B = '0; ALUControl = '0; fault_inj = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_status", 64'({fault_detected, uncorrectable}), 64'd0);
        check("rst_count", 64'(fault_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;

        // Fault-free table.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            check($sformatf("v%0d_result", i), 64'(Result), 64'(vecs[i].res));
            check($sformatf("v%0d_zcvn", i), 64'({Zero, Carry, OverFlow, Negative}), 64'(vecs[i].zcvn));
            check($sformatf("v%0d_status", i), 64'({fault_detected, uncorrectable}), 64'd0);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd0);
            finish_op();
        end
        check("nofault_count", 64'(fault_count), 64'd0);

        // Single-cycle fault in EX2, corrected by the vote.
        clear_sched();
        inj_sched[1] = 32'h1;
        run_op(32'd7, 32'd9, 3'b000, lat);
        check("vote_result", 64'(Result), 64'd16);
        check("vote_fault", 64'(fault_detected), 64'd1);
        check("vote_unc", 64'(uncorrectable), 64'd0);
        check("vote_latency", 64'(lat), 64'd4);
        check("vote_count", 64'(fault_count), 64'd1);
        finish_op();

        // Distinct masks in EX1/EX2/EX3 of every round: three rounds, then give up.
        clear_sched();
        for (int k = 0; k < 9; k++)
            inj_sched[k] = (k % 3 == 0) ? 32'h1 : (k % 3 == 1) ? 32'h2 : 32'h4;
        run_op(32'd7, 32'd9, 3'b000, lat);
        check("unc_result", 64'(Result), 64'd20);
        check("unc_flag", 64'(uncorrectable), 64'd1);
        check("unc_fault", 64'(fault_detected), 64'd1);
        check("unc_latency", 64'(lat), 64'd10);
        check("unc_count", 64'(fault_count), 64'd2);
        finish_op();

        // Backpressure: outputs held, new request ignored.
        clear_sched();
        run_op(32'd0, 32'd1, 3'b001, lat);
        in_valid = 1'b1; A = 32'd3; B = 32'd4; ALUControl = 3'b000;
        seen = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!out_valid || in_ready || Result !== 32'hFFFFFFFF ||
                {Zero, Carry, OverFlow, Negative} !== 4'b0001) seen = 1'b0;
        end
        check("bp_held", 64'(seen), 64'd1);
        check("bp_status", 64'({fault_detected, uncorrectable}), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_result_kept", 64'(Result), 64'hFFFFFFFF);

        // Saturation on the 2-bit counter and clear-wins-over-increment.
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_idle_small", 64'(s_count), 64'd0);
        check("clr_idle_main", 64'(fault_count), 64'd0);
        clear_sched();
        inj_sched[1] = 32'h1;
        for (int n = 0; n < 4; n++) begin
            run_op(32'd7, 32'd9, 3'b000, lat);
            finish_op();
        end
        check("sat_small", 64'(s_count), 64'd3);
        check("sat_main", 64'(fault_count), 64'd4);
        clr_sched[2] = 1'b1;
        run_op(32'd7, 32'd9, 3'b000, lat);
        check("clr_wins_small", 64'(s_count), 64'd0);
        check("clr_wins_main", 64'(fault_count), 64'd0);
        check("clr_wins_fault", 64'(fault_detected), 64'd1);
        finish_op();

        // Reset during EX2 aborts the operation.
        clear_sched();
        @(negedge clk);
        A = 32'd1; B = 32'd2; ALUControl = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_result", 64'(Result), 64'd0);
        check("mid_rst_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'd0);
        check("mid_rst_status", 64'({fault_detected, uncorrectable}), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", 64'(seen), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);

        run_op(32'd2, 32'd2, 3'b000, lat);
        check("post_rst_result", 64'(Result), 64'd4);
        check("post_rst_latency", 64'(lat), 64'd3);
        finish_op();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
